dma_mem_responder: RTL

Avalon-MM pipelined memory slave that answers the `dma_engine` master port: it accepts word reads and byte-enabled writes, returns read data with a fixed latency through `s_readdatavalid`, and bounds outstanding reads with `s_waitrequest`. It serves as the on-chip scratch buffer that DMA transfers read from and write into. It also closes the loop in `dma_engine` benches, replacing the tied-off `m_waitrequest`/`m_readdatavalid` stubs. An optional LFSR-driven stall generator exercises master backpressure handling.

---
 rtl/dma_mem_pkg.sv | 23 ++
 rtl/dma_mem_rd_pipe.sv | 27 ++
 rtl/dma_mem_responder.sv | 136 +++++++++++++
 3 files changed

// File: rtl/dma_mem_pkg.sv
// Shared constants and types for the DMA scratch-memory responder.
package dma_mem_pkg;

  // Fibonacci LFSR, taps 16,14,13,11 -> bit positions 15,13,12,10
  localparam logic [15:0] LFSR_SEED  = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;

  // Stall when both low LFSR bits are zero (about one cycle in four)
  localparam logic [1:0]  STALL_MASK = 2'b11;

  // Read pipeline payload width; the responder's WIDTHD must match it
  localparam int RD_PIPE_DW = 32;

  typedef struct packed {
    logic                  valid;
    logic [RD_PIPE_DW-1:0] data;
  } rd_pipe_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/dma_mem_rd_pipe.sv
// Fixed-latency read return pipeline (valid + data) with synchronous clear.
module dma_mem_rd_pipe
  import dma_mem_pkg::*;
#(
  parameter int LAT = 2
) (
  input  logic     i_clk,
  input  logic     i_clr,
  input  rd_pipe_t i_d,
  output rd_pipe_t o_q
);

  rd_pipe_t r_stage [LAT];

  // Shift the sampled read word toward the output; clear drops in-flight reads
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      for (int i = 0; i < LAT; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < LAT; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_q = r_stage[LAT-1];

endmodule

// File: rtl/dma_mem_responder.sv
// Avalon-MM pipelined scratch memory slave for the DMA engine: word reads with
// fixed latency, byte-enabled writes, bounded outstanding reads, optional
// pseudo-random backpressure.
module dma_mem_responder
  import dma_mem_pkg::*;
#(
  parameter int WIDTHA       = 24,
  parameter int WIDTHD       = 32,
  parameter int WIDTHB       = 4,
  parameter int DEPTH_LOG2   = 10,
  parameter int READ_LATENCY = 2,
  parameter int MAX_PENDING  = 2,
  parameter int STALL_EN     = 0
) (
  input  logic              clock,
  input  logic              clock_sreset,
  input  logic [WIDTHA-1:0] s_address,
  input  logic [WIDTHB-1:0] s_byteenable,
  input  logic [WIDTHD-1:0] s_writedata,
  input  logic              s_read,
  input  logic              s_write,
  output logic [WIDTHD-1:0] s_readdata,
  output logic              s_readdatavalid,
  output logic              s_waitrequest,
  output logic              s_err,
  output logic [31:0]       rd_count,
  output logic [31:0]       wr_count
);

  localparam int BO    = $clog2(WIDTHB);
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int PW    = $clog2(MAX_PENDING + 1);

  logic [WIDTHB-1:0][7:0] r_mem [DEPTH];
  logic [PW-1:0]          r_pending;
  logic                   r_err;
  logic [31:0]            r_rd_count;
  logic [31:0]            r_wr_count;

  logic [DEPTH_LOG2-1:0]  w_idx;
  logic [WIDTHB-1:0][7:0] w_mem_word;
  logic                   w_stall;
  logic                   w_acc;
  logic                   w_wr_acc;
  logic                   w_rd_acc;
  logic                   w_clash;
  rd_pipe_t               w_pipe_d;
  rd_pipe_t               w_pipe_q;
  logic                   w_unused_addr;

  // Upper address bits wrap, byte-offset bits are ignored
  assign w_idx         = s_address[BO+DEPTH_LOG2-1:BO];
  assign w_unused_addr = ^s_address;

  // Wait depends on registered state only; a returning read frees its slot
  // in the same cycle so a full pipe keeps streaming when limit == latency.
  assign s_waitrequest = w_stall |
                         ((r_pending == PW'(MAX_PENDING)) & ~w_pipe_q.valid);

  assign w_acc    = (s_read | s_write) & ~s_waitrequest & ~clock_sreset;
  assign w_wr_acc = w_acc & s_write;
  assign w_rd_acc = w_acc & s_read & ~s_write;
  assign w_clash  = w_acc & s_read & s_write;

  // Byte-lane RAM write; contents deliberately survive reset
  always_ff @(posedge clock) begin
    for (int i = 0; i < WIDTHB; i++)
      if (w_wr_acc && s_byteenable[i]) r_mem[w_idx][i] <= s_writedata[i*8 +: 8];
  end

  assign w_mem_word = r_mem[w_idx];
  assign w_pipe_d   = '{valid: w_rd_acc, data: RD_PIPE_DW'(w_mem_word)};

  dma_mem_rd_pipe #(.LAT(READ_LATENCY)) u_rd_pipe (
    .i_clk (clock),
    .i_clr (clock_sreset),
    .i_d   (w_pipe_d),
    .o_q   (w_pipe_q)
  );

  assign s_readdatavalid = w_pipe_q.valid;
  assign s_readdata      = WIDTHD'(w_pipe_q.data);

  // Outstanding-read tracking: +1 on read accept, -1 on each returned word
  always_ff @(posedge clock) begin
    if (clock_sreset) begin
      r_pending <= '0;
    end else begin
      case ({w_rd_acc, w_pipe_q.valid})
        2'b10:   r_pending <= r_pending + 1'b1;
        2'b01:   r_pending <= r_pending - 1'b1;
        default: r_pending <= r_pending;
      endcase
    end
  end

  // Sticky error on read+write collision, plus accept counters
  always_ff @(posedge clock) begin
    if (clock_sreset) begin
      r_err      <= 1'b0;
      r_rd_count <= '0;
      r_wr_count <= '0;
    end else begin
      if (w_clash)  r_err      <= 1'b1;
      if (w_rd_acc) r_rd_count <= r_rd_count + 32'd1;
      if (w_wr_acc) r_wr_count <= r_wr_count + 32'd1;
    end
  end

  assign s_err    = r_err;
  assign rd_count = r_rd_count;
  assign wr_count = r_wr_count;

  generate
    if (STALL_EN != 0) begin : g_stall
      logic [15:0] r_lfsr;
      logic        r_stall;

      // Free-running LFSR; stall decision registered from its current state
      always_ff @(posedge clock) begin
        if (clock_sreset) begin
          r_lfsr  <= LFSR_SEED;
          r_stall <= 1'b0;
        end else begin
          r_lfsr  <= lfsr_next(r_lfsr);
          r_stall <= ((r_lfsr[1:0] & STALL_MASK) == 2'b00);
        end
      end

      assign w_stall = r_stall;
    end else begin : g_nostall
      assign w_stall = 1'b0;
    end
  endgenerate

endmodule
